// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller (IDLE/ADDR/MEM/RESP).
// Define LSU_TIMEOUT_EN to enable the MEM-state abort timer.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_base,
  input  logic [5:0]  req_off,
  input  logic [15:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("lsu_ctrl: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    MEM  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic        we_q;
  logic [15:0] base_q;
  logic [5:0]  off_q;
  logic [15:0] wdata_q;
  logic [15:0] addr_q;
  logic [15:0] rdata_q;
  logic        accept;
  logic        tmo;
  logic        mem_done;

  assign accept   = req_valid && (state == IDLE);
  assign mem_done = (state == MEM) && (mem_ack || tmo);

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ADDR) begin
      cnt <= '0;
    end else if (state == MEM && !mem_ack) begin
      cnt <= cnt + 8'd1;
    end
  end

  // counter reaching the limit this cycle; an ack in the same cycle wins
  assign tmo = (state == MEM) && (cnt + 8'd1 == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (mem_done) begin
      err_q <= !mem_ack;
    end
  end

  assign rsp_err = err_q;
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = ADDR;
      ADDR:    state_nx = MEM;
      MEM:     if (mem_done) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    unique case (1'b1)
      state == IDLE: req_ready = 1'b1;
      state == MEM: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_wdata = wdata_q;
      end
      state == RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      base_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      base_q  <= req_base;
      off_q   <= req_off;
      wdata_q <= req_wdata;
    end
  end

  // sign-extended offset, carry out of bit 15 dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (state == ADDR) begin
      addr_q <= base_q + {{10{off_q[5]}}, off_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (mem_done) begin
      rdata_q <= (mem_ack && !we_q) ? mem_rdata : 16'h0000;
    end
  end

  assign mem_addr  = addr_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized transaction bench for lsu_ctrl.
// Expected results come from a transaction-level model of the access rules.
module tb_lsu_ctrl;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_base;
  logic [5:0]  req_off;
  logic [15:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  int checks;
  int failures;
  int rsp_cnt;
  int ntxn;
  logic [15:0] last_addr;
  logic [15:0] last_rd;
  logic        last_err;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_base  (req_base),
    .req_off   (req_off),
    .req_wdata (req_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rsp_cnt = 0;
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rsp_cnt = rsp_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      tick();
      mem_ack = 1'b0;
      chk("gap_ready", req_ready, 1);
      chk("gap_memreq", mem_req, 0);
      chk("gap_rspv", rsp_valid, 0);
      chk("gap_addr", mem_addr, last_addr);
    end
  endtask

  task automatic run_txn(input logic        we,
                         input logic [15:0] base,
                         input logic [5:0]  off,
                         input logic [15:0] wdata,
                         input logic [15:0] rdata,
                         input int          waits,
                         input logic        hold);
    int          eff;
    int          ncyc;
    logic [15:0] exp_addr;
    logic [15:0] exp_rd;
    logic        exp_err;
    eff      = int'(base) + (off[5] ? int'(off) - 64 : int'(off));
    exp_addr = eff[15:0];
    exp_err  = 1'b0;
    ncyc     = waits + 1;
`ifdef LSU_TIMEOUT_EN
    if (waits >= TO) begin
      exp_err = 1'b1;
      ncyc    = TO;
    end
`endif
    exp_rd = (we || exp_err) ? 16'h0000 : rdata;

    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_base  = base;
    req_off   = off;
    req_wdata = wdata;
    tick();
    req_valid = hold;
    if (hold) begin
      req_we    = 1'($urandom);
      req_base  = 16'($urandom);
      req_off   = 6'($urandom);
      req_wdata = 16'($urandom);
    end

    chk("addr_ready", req_ready, 0);
    chk("addr_memreq", mem_req, 0);
    chk("addr_hold", mem_addr, last_addr);
    chk("addr_rspv", rsp_valid, 0);
    chk("rdata_hold", rsp_rdata, last_rd);
    chk("err_hold", rsp_err, last_err);
    tick();

    for (int k = 0; k < ncyc; k++) begin
      chk("mem_req", mem_req, 1);
      chk("mem_we", mem_we, we);
      chk("mem_wdata", mem_wdata, wdata);
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_rspv", rsp_valid, 0);
      chk("mem_ready", req_ready, 0);
      mem_ack   = (k == waits);
      mem_rdata = (k == waits) ? rdata : 16'($urandom);
      tick();
      mem_ack = 1'b0;
    end

    chk("resp_valid", rsp_valid, 1);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_err", rsp_err, exp_err);
    chk("resp_memreq", mem_req, 0);
    chk("resp_memwe", mem_we, 0);
    chk("resp_wdata", mem_wdata, 0);
    chk("resp_ready", req_ready, 0);
    mem_ack = 1'($urandom_range(0, 1));
    tick();
    mem_ack   = 1'b0;
    req_valid = 1'b0;

    chk("post_ready", req_ready, 1);
    chk("post_rspv", rsp_valid, 0);
    chk("post_rdata", rsp_rdata, exp_rd);
    chk("post_addr", mem_addr, exp_addr);
    last_addr = exp_addr;
    last_rd   = exp_rd;
    last_err  = exp_err;
    ntxn      = ntxn + 1;
  endtask

  initial begin
    int w;
    checks    = 0;
    failures  = 0;
    ntxn      = 0;
    last_addr = 16'h0000;
    last_rd   = 16'h0000;
    last_err  = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_base  = '0;
    req_off   = '0;
    req_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    #12;
    chk("rst_memreq", mem_req, 0);
    chk("rst_memwe", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", req_ready, 1);

    run_txn(1'b0, 16'h1000, 6'b000101, 16'h0000, 16'hBEEF, 0, 1'b0);
    chk("dir_addr_1005", mem_addr, 16'h1005);
    run_txn(1'b1, 16'h0010, 6'b100000, 16'h1234, 16'h5555, 4, 1'b1);
    chk("dir_addr_fff0", mem_addr, 16'hFFF0);
    run_txn(1'b0, 16'hFFFF, 6'b000001, 16'h0000, 16'hA5A5, 1, 1'b0);
    chk("dir_wrap_0000", mem_addr, 16'h0000);
    run_txn(1'b0, 16'h0000, 6'b111111, 16'h0000, 16'h0F0F, 2, 1'b0);
    chk("dir_wrap_ffff", mem_addr, 16'hFFFF);
    idle_gap(3);

`ifdef LSU_TIMEOUT_EN
    run_txn(1'b0, 16'h2000, 6'b000011, 16'h0000, 16'hCAFE, TO + 3, 1'b0);
    run_txn(1'b0, 16'h3000, 6'b000100, 16'h0000, 16'hD00D, TO - 1, 1'b0);
    run_txn(1'b1, 16'h4000, 6'b000001, 16'h7777, 16'h1111, TO, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(0, 6);
`ifdef LSU_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) w = $urandom_range(TO - 2, TO + 1);
`endif
      run_txn(1'($urandom), 16'($urandom), 6'($urandom), 16'($urandom),
              16'($urandom), w, 1'($urandom));
      idle_gap($urandom_range(0, 2));
    end

    req_valid = 1'b1;
    req_we    = 1'b1;
    req_base  = 16'h5A5A;
    req_off   = 6'b000010;
    req_wdata = 16'h9999;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_memreq", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_memreq", mem_req, 0);
    chk("async_memwe", mem_we, 0);
    chk("async_addr", mem_addr, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rel2_ready", req_ready, 1);
    chk("rel2_rspv", rsp_valid, 0);
    chk("rel2_rdata", rsp_rdata, 0);
    chk("rel2_err", rsp_err, 0);
    last_addr = 16'h0000;
    last_rd   = 16'h0000;
    last_err  = 1'b0;
    idle_gap(2);

    run_txn(1'b0, 16'h0100, 6'b011111, 16'h0000, 16'h4242, 2, 1'b0);
    tick();
    chk("rsp_count", rsp_cnt, ntxn);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, number of MEM-state cycles without mem_ack before abort (used only with LSU_TIMEOUT_EN); legal range 1..255.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  core load/store request.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_base  input  16  base register value.
REQ-008 req_off  input  6  two's-complement offset field from the instruction.
REQ-009 req_wdata  input  16  store data.
REQ-010 mem_req  output  1  memory access request; held until acknowledged.
REQ-011 mem_we  output  1  write strobe qualifying mem_req.
REQ-012 mem_addr  output  16  effective address.
REQ-013 mem_wdata  output  16  store data to memory.
REQ-014 mem_ack  input  1  memory completion, one-cycle pulse.
REQ-015 mem_rdata  input  16  load data, valid in the mem_ack cycle.
REQ-016 rsp_valid  output  1  one-cycle completion pulse to core.
REQ-017 rsp_rdata  output  16  load result; 0 for stores and aborts.
REQ-018 rsp_err  output  1  access aborted by timeout; qualified by rsp_valid.

Function
REQ-019 FSM states IDLE, ADDR, MEM, RESP; all outputs registered or decoded from state only.
REQ-020 req_ready = 1 only in IDLE; request accepted on an edge where req_valid & req_ready; IDLE->ADDR; we, base, off, wdata captured.
REQ-021 ADDR (one cycle): mem_addr <= base + {10 copies of off[5], off}, modulo 2^16; carry discarded; ADDR->MEM.
REQ-022 MEM: mem_req = 1, mem_we = captured we, mem_wdata = captured wdata, mem_addr stable for the whole state.
REQ-023 mem_ack sampled high in MEM: rsp_rdata <= mem_rdata for load, 0 for store; rsp_err <= 0; MEM->RESP; mem_req deasserts the next cycle.
REQ-024 RESP (one cycle): rsp_valid = 1; RESP->IDLE unconditionally; no new request accepted in RESP.
REQ-025 Latency: ack in first MEM cycle -> rsp_valid high in the 3rd cycle after the accept edge; each extra wait cycle adds 1.
REQ-026 mem_ack outside MEM ignored; req_valid outside IDLE ignored (not queued).
REQ-027 mem_we, mem_wdata driven 0 outside MEM; mem_addr holds last value outside ADDR update.
REQ-028 rsp_rdata, rsp_err hold their values until the next RESP.

Reset
REQ-029 rst_n low forces IDLE immediately, regardless of clock, including mid-access.
REQ-030 Reset values: req_ready 1 after release, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, timeout counter 0.
REQ-031 In-flight access at reset is dropped; no rsp_valid is produced for it.

Configuration
REQ-032 Macro LSU_TIMEOUT_EN defined: counter cleared on MEM entry, incremented each MEM cycle without mem_ack; on reaching TIMEOUT_CYCLES -> RESP with rsp_err = 1, rsp_rdata = 0, mem_req dropped next cycle.
REQ-033 mem_ack in the same cycle the counter reaches TIMEOUT_CYCLES: ack wins, rsp_err = 0.
REQ-034 Macro undefined: no counter, MEM waits indefinitely, rsp_err tied 0, TIMEOUT_CYCLES unused.

Verification
REQ-035 Load base 0x1000, off 6'b000101, ack first MEM cycle with rdata 0xBEEF -> mem_addr 0x1005, mem_we 0, rsp_valid 3 cycles after accept, rsp_rdata 0xBEEF, rsp_err 0.
REQ-036 Store base 0x0010, off 6'b100000 (-32), wdata 0x1234, ack after 4 wait cycles -> mem_addr 0xFFF0, mem_we 1, mem_wdata 0x1234, mem_req high 5 cycles, rsp_rdata 0.
REQ-037 Load base 0xFFFF, off 6'b000001 -> mem_addr 0x0000 (wrap); off 6'b111111 on base 0x0000 -> 0xFFFF.
REQ-038 Stray mem_ack in IDLE and req_valid held during MEM -> no state change, exactly one rsp_valid per accepted request.
REQ-039 rst_n asserted mid-MEM with mem_req high -> mem_req 0 without clock edge, req_ready 1 after release, no rsp_valid.
REQ-040 LSU_TIMEOUT_EN, TIMEOUT_CYCLES 16, no ack -> rsp_valid with rsp_err 1 after 16 MEM cycles; ack on 16th cycle -> rsp_err 0 with data.
